// File: rtl/mult5appx_acc_pkg.sv
// Shared types and default sizing for the approximate-product batch accumulator.
package mult5appx_acc_pkg;

  localparam int DEFAULT_ACC_W = 12;
  localparam int DEFAULT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult5appx_acc_sat_add.sv
// Unsigned saturating adder: ACC_W-bit running sum plus a 5-bit approximate product.
module sat_add #(
  parameter int ACC_W = 12
) (
  input  logic [ACC_W-1:0] a,
  input  logic [4:0]       b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic [ACC_W:0] wide_sum_s;

  assign wide_sum_s = (ACC_W+1)'(a) + (ACC_W+1)'(b);

  // Clamp to all-ones whenever the carry-out is set
  always_comb begin
    ovf = wide_sum_s[ACC_W];
    sum = wide_sum_s[ACC_W-1:0];
    if (wide_sum_s[ACC_W]) begin
      sum = {ACC_W{1'b1}};
    end else begin
      sum = wide_sum_s[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/mult5appx_acc.sv
// Accumulates batches of 5-bit approximate products with saturation and a
// valid/ready handshake on both the sample input and the batch result.
module mult5appx_acc
  import mult5appx_acc_pkg::*;
#(
  parameter int ACC_W = DEFAULT_ACC_W,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       y,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CNT_W-1:0] batch_len,
  output logic [ACC_W-1:0] acc_out,
  output logic             sat,
  output logic             out_valid,
  input  logic             out_ready
);

  state_t           state_r, state_s;
  logic [ACC_W-1:0] acc_r, acc_s;
  logic             sat_r, sat_s;
  logic [CNT_W-1:0] remaining_r, remaining_s;
  logic             accept_s;
  logic [ACC_W-1:0] add_sum_s;
  logic             add_ovf_s;

  sat_add #(.ACC_W(ACC_W)) u_sat_add (
    .a   (acc_r),
    .b   (y),
    .sum (add_sum_s),
    .ovf (add_ovf_s)
  );

  // Handshake flags decode the state register; reset masks them immediately
  assign in_ready  = (state_r != DONE) && !rst;
  assign out_valid = (state_r == DONE) && !rst;
  assign accept_s  = in_valid && in_ready;
  assign acc_out   = acc_r;
  assign sat       = sat_r;

  // Next-state and datapath update; batch_len-1 wraps so 0 means a full 2^CNT_W batch
  always_comb begin
    state_s     = state_r;
    acc_s       = acc_r;
    sat_s       = sat_r;
    remaining_s = remaining_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          acc_s       = ACC_W'(y);
          sat_s       = 1'b0;
          remaining_s = batch_len - CNT_W'(1);
          if (batch_len == CNT_W'(1)) begin
            state_s = DONE;
          end else begin
            state_s = ACC;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ACC: begin
        if (accept_s) begin
          acc_s       = add_sum_s;
          sat_s       = sat_r | add_ovf_s;
          remaining_s = remaining_r - CNT_W'(1);
          if (remaining_r == CNT_W'(1)) begin
            state_s = DONE;
          end else begin
            state_s = ACC;
          end
        end else begin
          state_s = ACC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s     = IDLE;
          acc_s       = {ACC_W{1'b0}};
          sat_s       = 1'b0;
          remaining_s = {CNT_W{1'b0}};
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s     = IDLE;
        acc_s       = {ACC_W{1'b0}};
        sat_s       = 1'b0;
        remaining_s = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      acc_r       <= {ACC_W{1'b0}};
      sat_r       <= 1'b0;
      remaining_r <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_s;
      acc_r       <= acc_s;
      sat_r       <= sat_s;
      remaining_r <= remaining_s;
    end
  end

endmodule

// File: tb/tb_mult5appx_acc.sv
// Directed self-checking bench: default-width and 6-bit-accumulator instances share stimulus.
module tb_mult5appx_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  y;
  logic        in_valid;
  logic [3:0]  batch_len;
  logic        out_ready;

  logic        in_ready_a, sat_a, out_valid_a;
  logic [11:0] acc_out_a;
  logic        in_ready_b, sat_b, out_valid_b;
  logic [5:0]  acc_out_b;

  int checks   = 0;
  int failures = 0;

  mult5appx_acc #(.ACC_W(12), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .y(y), .in_valid(in_valid), .in_ready(in_ready_a),
    .batch_len(batch_len), .acc_out(acc_out_a), .sat(sat_a),
    .out_valid(out_valid_a), .out_ready(out_ready)
  );

  mult5appx_acc #(.ACC_W(6), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .y(y), .in_valid(in_valid), .in_ready(in_ready_b),
    .batch_len(batch_len), .acc_out(acc_out_b), .sat(sat_b),
    .out_valid(out_valid_b), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; y = 5'd0; in_valid = 1'b0; batch_len = 4'd0; out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", in_ready_a, 0);
    check("rst_out_valid", out_valid_a, 0);
    check("rst_acc", acc_out_a, 0);
    check("rst_sat", sat_a, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready_a, 1);
    tick();

    // Three-sample batch, back-to-back
    batch_len = 4'd3; out_ready = 1'b1; in_valid = 1'b1;
    y = 5'd5; tick();
    y = 5'd7; tick();
    check("b3_mid_out_valid", out_valid_a, 0);
    check("b3_mid_acc", acc_out_a, 12);
    y = 5'd9; tick();
    in_valid = 1'b0;
    check("b3_out_valid", out_valid_a, 1);
    check("b3_acc", acc_out_a, 21);
    check("b3_sat", sat_a, 0);
    check("b3_in_ready_done", in_ready_a, 0);
    tick();
    check("b3_idle_out_valid", out_valid_a, 0);
    check("b3_idle_in_ready", in_ready_a, 1);
    check("b3_idle_acc_clr", acc_out_a, 0);

    // Saturation on the 6-bit instance
    batch_len = 4'd3; in_valid = 1'b1; y = 5'd31;
    tick(); tick(); tick();
    in_valid = 1'b0;
    check("s6_out_valid", out_valid_b, 1);
    check("s6_acc", acc_out_b, 63);
    check("s6_sat", sat_b, 1);
    check("s12_acc", acc_out_a, 93);
    check("s12_sat", sat_a, 0);
    tick();
    check("s6_sat_clr", sat_b, 0);

    // Sat stays set after a later non-overflowing sample
    batch_len = 4'd4; in_valid = 1'b1; y = 5'd31;
    tick(); tick(); tick();
    y = 5'd0; tick();
    in_valid = 1'b0;
    check("sticky_acc", acc_out_b, 63);
    check("sticky_sat", sat_b, 1);
    check("sticky_out_valid", out_valid_b, 1);
    tick();

    // batch_len 0 means 16 samples; then hold in DONE
    batch_len = 4'd0; out_ready = 1'b0; in_valid = 1'b1; y = 5'd1;
    for (int i = 0; i < 15; i++) tick();
    check("b16_15_out_valid", out_valid_a, 0);
    check("b16_15_acc", acc_out_a, 15);
    tick();
    check("b16_out_valid", out_valid_a, 1);
    check("b16_acc", acc_out_a, 16);
    y = 5'd20;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("done_in_ready", in_ready_a, 0);
      check("done_out_valid", out_valid_a, 1);
      check("done_acc_stable", acc_out_a, 16);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("done_xfer_out_valid", out_valid_a, 0);
    check("done_xfer_in_ready", in_ready_a, 1);
    check("done_xfer_acc", acc_out_a, 0);

    // Reset mid-batch discards the partial sum
    batch_len = 4'd4; in_valid = 1'b1;
    y = 5'd2; tick();
    y = 5'd3; tick();
    in_valid = 1'b0;
    check("mid_acc", acc_out_a, 5);
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", in_ready_a, 0);
    tick();
    check("mid_rst_out_valid", out_valid_a, 0);
    check("mid_rst_acc", acc_out_a, 0);
    rst = 1'b0;
    tick();
    check("mid_after_out_valid", out_valid_a, 0);
    check("mid_after_in_ready", in_ready_a, 1);
    batch_len = 4'd1; in_valid = 1'b1; y = 5'd4; tick();
    in_valid = 1'b0;
    check("b1_out_valid", out_valid_a, 1);
    check("b1_acc", acc_out_a, 4);
    tick();

    // batch_len change after first accept is ignored; an idle cycle holds state
    out_ready = 1'b0; batch_len = 4'd2; in_valid = 1'b1; y = 5'd3; tick();
    batch_len = 4'd7; in_valid = 1'b0; y = 5'd30; tick();
    check("hold_out_valid", out_valid_a, 0);
    check("hold_acc", acc_out_a, 3);
    in_valid = 1'b1; y = 5'd3; tick();
    in_valid = 1'b0;
    check("blen_out_valid", out_valid_a, 1);
    check("blen_acc", acc_out_a, 6);
    out_ready = 1'b1;
    tick();
    check("blen_idle", out_valid_a, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
